// File: rtl/range_sweep_if.sv
// Bundle shared by the sweep controller, its two requesters and the up/down counter.
// The master modport is the controller's view; slave is the requester/counter side.
interface range_sweep_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] start_val0;
  logic [WIDTH-1:0] end_val0;
  logic [WIDTH-1:0] start_val1;
  logic [WIDTH-1:0] end_val1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [1:0]       err;
  logic             busy;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_u_d;
  logic             cnt_en;

  modport master (
    input  req, start_val0, end_val0, start_val1, end_val1, cnt_count,
    output gnt, done, err, busy, cnt_load, cnt_data, cnt_u_d, cnt_en
  );

  modport slave (
    output req, start_val0, end_val0, start_val1, end_val1, cnt_count,
    input  gnt, done, err, busy, cnt_load, cnt_data, cnt_u_d, cnt_en
  );
endinterface

// File: rtl/range_sweep_ctrl.sv
// Round-robin sweep sequencer for a shared up/down range counter. Grants one of two
// requesters, loads its start value, counts toward its end value and pulses done, or
// pulses err if the watchdog expires first.
module range_sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 300  // max RUN cycles; keep >= 2**WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  range_sweep_if.master bus
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StAbort} state_e;

  state_e           state_q;
  logic             rr_q;
  logic             owner_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             dir_q;
  logic [WdW-1:0]   wd_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic             busy_q;
  logic             load_q;
  logic [WIDTH-1:0] data_q;
  logic             u_d_q;

  logic             pick;
  logic [WIDTH-1:0] sel_start;
  logic [WIDTH-1:0] sel_end;
  logic             sel_dir;

  // Owner selection: round-robin pointer breaks ties, otherwise the lone requester wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11) begin
      pick = rr_q;
    end else begin
      pick = bus.req[1];
    end
    sel_start = pick ? bus.start_val1 : bus.start_val0;
    sel_end   = pick ? bus.end_val1   : bus.end_val0;
    sel_dir   = (sel_end >= sel_start);
  end

  // Sequencer: state, latched sweep bounds, watchdog and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      wd_q    <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= '0;
      u_d_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            owner_q <= pick;
            start_q <= sel_start;
            end_q   <= sel_end;
            dir_q   <= sel_dir;
            gnt_q   <= pick ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
            data_q  <= sel_start;
            u_d_q   <= sel_dir;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // Counter captures start on this edge; RUN sees it from the first cycle.
          load_q  <= 1'b0;
          data_q  <= '0;
          wd_q    <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (bus.cnt_count == end_q) begin
            done_q  <= gnt_q;
            u_d_q   <= 1'b0;
            state_q <= StDone;
          end else if (wd_q == WdLast) begin
            err_q   <= gnt_q;
            u_d_q   <= 1'b0;
            state_q <= StAbort;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StDone, StAbort: begin
          done_q  <= 2'b00;
          err_q   <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          rr_q    <= ~owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.cnt_load = load_q;
  assign bus.cnt_data = data_q;
  assign bus.cnt_u_d  = u_d_q;
  // Combinational so the enable drops in the very cycle the count matches (no overshoot).
  assign bus.cnt_en   = (state_q == StRun) && (bus.cnt_count != end_q);

endmodule

// File: tb/tb_range_sweep_ctrl.sv
// Self-checking bench for range_sweep_ctrl with a behavioural up/down counter and a
// per-sweep expectation model (owner, latency, enabled cycles, outcome).
module tb_range_sweep_ctrl;

  localparam int W  = 8;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  range_sweep_if #(.WIDTH(W)) bus ();

  range_sweep_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     exp_rr  = 1'b0;
  bit     freeze  = 1'b0;
  logic [W-1:0] cnt;

  // Counter under control; freeze models a counter stuck by its own range clamping.
  always @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (freeze)        cnt <= 8'd5;
    else if (bus.cnt_load)  cnt <= bus.cnt_data;
    else if (bus.cnt_en)    cnt <= bus.cnt_u_d ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign bus.cnt_count = cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // One sweep starting from an IDLE-cycle negedge; returns at the following IDLE negedge.
  task automatic sweep(input bit [1:0] reqs, input logic [W-1:0] s0, input logic [W-1:0] e0,
                       input logic [W-1:0] s1, input logic [W-1:0] e1,
                       input bit frz, input bit hold, input bit disturb);
    bit           own;
    bit           dir;
    bit           fin;
    logic [W-1:0] s;
    logic [W-1:0] e;
    logic [W-1:0] ld_data;
    logic         ld_dir;
    logic [1:0]   oh;
    logic [3:0]   pulse;
    logic         en_end;
    logic [W-1:0] cnt_end;
    int           n, p_gnt, p_end, loads, ens, bad_dir, bad_gnt;
    own  = (reqs == 2'b11) ? exp_rr : reqs[1];
    s    = own ? s1 : s0;
    e    = own ? e1 : e0;
    dir  = (e >= s);
    n    = dir ? int'(e) - int'(s) : int'(s) - int'(e);
    oh   = own ? 2'b10 : 2'b01;
    fin  = 1'b0;
    p_gnt = -1; p_end = -1; loads = 0; ens = 0; bad_dir = 0; bad_gnt = 0;
    ld_data = '0; ld_dir = 1'b0; pulse = '0; en_end = 1'b0; cnt_end = '0;
    freeze = frz;
    bus.start_val0 = s0; bus.end_val0 = e0;
    bus.start_val1 = s1; bus.end_val1 = e1;
    bus.req = reqs;
    for (int p = 1; p <= TO + 20 && !fin; p++) begin
      @(posedge clk); @(negedge clk);
      if (bus.gnt != 2'b00 && p_gnt < 0) p_gnt = p;
      if (bus.gnt != 2'b00 && bus.gnt != oh) bad_gnt++;
      if (bus.cnt_load) begin
        loads++; ld_data = bus.cnt_data; ld_dir = bus.cnt_u_d;
      end
      if (bus.cnt_en) begin
        ens++;
        if (bus.cnt_u_d != dir) bad_dir++;
      end
      if (bus.done != 2'b00 || bus.err != 2'b00) begin
        p_end = p; pulse = {bus.done, bus.err}; en_end = bus.cnt_en; cnt_end = cnt; fin = 1'b1;
      end else if (disturb && p == 4) begin
        // Owner changes its end value and withdraws mid-RUN; both must be ignored.
        if (own) bus.end_val1 = ~e; else bus.end_val0 = ~e;
        bus.req[own] = 1'b0;
      end
    end
    if (!hold) bus.req[own] = 1'b0;
    check("gnt_latency", p_gnt, 1);
    check("gnt_owner", bad_gnt, 0);
    check("load_count", loads, 1);
    check("load_data", ld_data, s);
    check("load_dir", ld_dir, dir);
    check("run_dir", bad_dir, 0);
    check("en_cycles", ens, frz ? TO : n);
    check("end_cycle", p_end, frz ? TO + 2 : n + 3);
    check("outcome", pulse, frz ? {2'b00, oh} : {oh, 2'b00});
    check("en_at_end", en_end, 0);
    if (!frz) check("final_count", cnt_end, e);
    @(posedge clk); @(negedge clk);
    check("idle_outs", {bus.gnt, bus.done, bus.err, bus.busy, bus.cnt_en}, 0);
    exp_rr = ~own;
    freeze = 1'b0;
  endtask

  initial begin
    bit [1:0]     r;
    logic [W-1:0] sa, ea, sb, eb;
    bus.req = 2'b00;
    bus.start_val0 = '0; bus.end_val0 = '0; bus.start_val1 = '0; bus.end_val1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.gnt, bus.done, bus.err, bus.busy, bus.cnt_load, bus.cnt_data,
                         bus.cnt_u_d, bus.cnt_en}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Both requesting from reset: 0 first, then strict alternation while both stay high.
    sweep(2'b11, 8'd3, 8'd6, 8'd9, 8'd5, 1'b0, 1'b1, 1'b0);
    sweep(2'b11, 8'd3, 8'd6, 8'd9, 8'd5, 1'b0, 1'b1, 1'b0);
    sweep(2'b11, 8'd100, 8'd101, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
    sweep(2'b11, 8'd100, 8'd101, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0);

    // Directed sweeps: up, down, zero length.
    sweep(2'b01, 8'd10, 8'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    sweep(2'b10, 8'd0, 8'd0, 8'd50, 8'd47, 1'b0, 1'b0, 1'b0);
    sweep(2'b10, 8'd0, 8'd0, 8'd20, 8'd20, 1'b0, 1'b0, 1'b0);

    // Watchdog abort on a stuck counter, then a normal sweep.
    sweep(2'b01, 8'd0, 8'd100, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    sweep(2'b01, 8'd40, 8'd33, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Mid-sweep disturbance of end value and request.
    sweep(2'b01, 8'd30, 8'd60, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    // Reset during RUN cycle 30 (pointer is 1 going in).
    check("rr_before_rst", exp_rr, 1);
    bus.start_val0 = 8'd0; bus.end_val0 = 8'd200; bus.req = 2'b01;
    repeat (31) begin @(posedge clk); @(negedge clk); end
    check("pre_rst", {bus.gnt, bus.busy, bus.cnt_en}, 4'b0111);
    rst = 1'b0;
    #1;
    check("rst_async", {bus.gnt, bus.done, bus.err, bus.busy, bus.cnt_en, bus.cnt_load}, 0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_held", {bus.gnt, bus.done, bus.err, bus.busy}, 0);
    rst = 1'b1;
    exp_rr = 1'b0;
    @(negedge clk);
    sweep(2'b11, 8'd1, 8'd4, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0);

    // Randomized rounds against the model.
    for (int i = 0; i < 25; i++) begin
      r  = 2'($urandom_range(1, 3));
      sa = 8'($urandom_range(0, 255));
      ea = 8'($urandom_range(sa > 30 ? sa - 30 : 0, sa < 225 ? sa + 30 : 255));
      sb = 8'($urandom_range(0, 255));
      eb = 8'($urandom_range(sb > 30 ? sb - 30 : 0, sb < 225 ? sb + 30 : 255));
      sweep(r, sa, ea, sb, eb, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/range_sweep_ctrl.md
Name: range_sweep_ctrl

Overview:
- Sequencer and arbiter for a shared up/down range counter with `load`, `data` and direction inputs.
- Two requesters each ask for a sweep from a start value to an end value.
- The controller grants one requester, loads the start value, and enables counting in the correct direction until the counter reads the end value. It then pulses done to that requester.
- Arbitration is round-robin. A watchdog aborts sweeps that never reach their end value.

Parameters:
- WIDTH, 8, counter and bound width.
- TIMEOUT, 300, maximum RUN cycles before abort; must be ≥ 2^WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; held high until that requester's done or err pulse.
- start_val0  in  WIDTH  sweep start value, requester 0.
- end_val0  in  WIDTH  sweep end value, requester 0.
- start_val1  in  WIDTH  sweep start value, requester 1.
- end_val1  in  WIDTH  sweep end value, requester 1.
- gnt  out  2  one-hot grant; high from acceptance through the DONE/ABORT cycle.
- done  out  2  one-cycle pulse to the owner on successful completion.
- err  out  2  one-cycle pulse to the owner on watchdog abort.
- busy  out  1  state != IDLE.
- cnt_count  in  WIDTH  current counter value (registered output of the counter).
- cnt_load  out  1  counter load strobe.
- cnt_data  out  WIDTH  counter load value.
- cnt_u_d  out  1  counter direction; 1 = up.
- cnt_en  out  1  counter count enable.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0.
  - All outputs are 0: gnt, done, err, busy, cnt_load, cnt_data, cnt_u_d, cnt_en.
  - Latched start, end and direction registers are cleared.
  - Reset asserted mid-sweep aborts the sweep silently (no done/err) and forces all outputs to 0 immediately.
- States: IDLE, LOAD, RUN, DONE, ABORT.
- IDLE:
  - If any req bit is set, pick the owner: if both are set, rr_ptr wins; otherwise the single requester wins.
  - Latch the owner's start/end values. Set dir = (end >= start).
  - Assert gnt[owner] registered; go to LOAD.
- LOAD (1 cycle):
  - cnt_load=1, cnt_data=latched start, cnt_u_d=dir.
  - The counter holds start from the next edge. Go to RUN; clear the watchdog.
- RUN:
  - cnt_u_d=dir. cnt_en is combinational: 1 when state==RUN and cnt_count != end_latched, else 0.
  - No overshoot: the enable drops in the same cycle the count matches.
  - If cnt_count==end: go to DONE.
  - Else if watchdog==TIMEOUT-1: go to ABORT.
  - Otherwise increment the watchdog.
  - start==end → first RUN cycle matches, cnt_en never asserts, sweep lasts exactly 1 RUN cycle.
- DONE (1 cycle): done[owner]=1, gnt held. Next: IDLE, gnt=0, rr_ptr=~owner.
- ABORT (1 cycle): err[owner]=1, cnt_en=0. Next: IDLE, gnt=0, rr_ptr=~owner.
- Latency:
  - Request to gnt: 1 cycle.
  - Request to done: |end−start| + 4 cycles (IDLE accept, LOAD, RUN × (|end−start|+1), DONE).
- Input sampling:
  - start/end values are sampled only at acceptance; changes during a sweep are ignored.
  - A req drop by the owner mid-sweep is ignored; the sweep completes.
- Back-to-back: after DONE/ABORT the controller spends one IDLE cycle before the next grant. A still-high req from the same owner loses to a pending other requester.
- No wrap-around is commanded: direction is always toward end. The counter's own range clamping (e.g. forcing 0) shows up as non-match and ends in ABORT via the watchdog.

Test Plan:
- Single up sweep: req0, start=10, end=15 → gnt0 after 1 cycle, cnt_load once with data=10, cnt_u_d=1, cnt_en for 5 cycles, done0 at cycle 9, gnt0 low at cycle 10.
- Down sweep and zero-length: req1, start=50, end=47 → cnt_u_d=0, 3 enabled cycles, done1. Then start=end=20 → cnt_en never high, done1 4 cycles after request.
- Arbitration: req=2'b11 from reset → req0 served first, then req1. Keep both high → grants alternate 0,1,0,1 with one IDLE cycle between sweeps.
- Watchdog: TIMEOUT=16, counter model frozen at 5, end=100 → err0 after 16 RUN cycles, no done, cnt_en=0 in ABORT, next request accepted normally.
- Reset mid-RUN: start=0, end=200, assert rst at RUN cycle 30 → gnt, cnt_en, busy go 0 asynchronously, no done/err, rr_ptr=0 after release.
- Input disturbance: change end_val0 and drop req0 mid-sweep → sweep still ends at the originally latched end, done0 pulses once.
